digit_entry: RTL and testbench
==============================

# digit_entry

Keypad-style decimal entry stage downstream of the switch-to-digit decoder. Takes the decoder's 4-bit digit plus three raw push buttons (enter, go, clear), debounces them, and shifts digits into a BCD display register and a running binary value. On "go" it hands the binary operand to the square-root core with a one-cycle start pulse. It then locks entry until the core reports completion.

## Interface
- `NDIG`, 4: maximum number of decimal digits accepted.
- `VW`, 14: width of the binary value; must satisfy 2^VW > 10^NDIG − 1.
- `DEB_CNT`, 50000: number of consecutive stable samples required to accept a key level (1 ms at 50 MHz).

Ports (clock and reset first):
- `clk`  in  1: single system clock.
- `reset`  in  1: synchronous, active-high.
- `dec`  in  4: current digit from the switch decoder, nominally 0–9.
- `key_enter_n`  in  1: raw enter button, active-low, asynchronous.
- `key_go_n`  in  1: raw go button, active-low, asynchronous.
- `key_clr_n`  in  1: raw clear button, active-low, asynchronous.
- `busy`  in  1: square-root core busy flag.
- `bcd`  out  4*NDIG: entered digits, most recent digit in the low nibble.
- `ndig`  out  3: number of digits entered, 0..NDIG.
- `value`  out  VW: binary equivalent of `bcd`.
- `start`  out  1: one-cycle launch pulse to the core.
- `locked`  out  1: high while waiting for the core.

## Operation
- Each key goes through a 2-FF synchronizer and then a debounce counter.
  - The debounced level changes only after `DEB_CNT` consecutive samples that differ from the current level; any agreeing sample resets the counter.
  - A press event is a one-cycle pulse on the debounced 1→0 transition. Releases generate no event.
- States: `ENTRY`, `LAUNCH`, `WAIT_BUSY`, `WAIT_DONE`.
- In `ENTRY`, event priority when several events coincide: clear > go > enter.
  - clear: `bcd`, `value` and `ndig` go to 0.
  - go: if `ndig` > 0, move to `LAUNCH`; if `ndig` == 0, ignore.
  - enter, when `ndig` < NDIG and `dec` ≤ 9:
    - `bcd` ← {bcd[4*NDIG−5:0], dec}
    - `value` ← (value<<3) + (value<<1) + dec, computed in VW bits; it cannot overflow by construction.
    - `ndig` increments.
  - enter when `ndig` == NDIG, or when `dec` > 9: ignored, no state change.
- `LAUNCH`: `start` = 1 for exactly this one cycle, then move unconditionally to `WAIT_BUSY`.
- `WAIT_BUSY`: wait for `busy` = 1, then move to `WAIT_DONE`.
- `WAIT_DONE`: wait for `busy` = 0, then return to `ENTRY`.
- In `LAUNCH`, `WAIT_BUSY` and `WAIT_DONE`, `locked` = 1 and all key events, including clear, are discarded. `value` and `bcd` are held stable for the core.
- Digits are retained on return to `ENTRY`. Pressing go again relaunches with the same operand.

## Timing
- Reset state:
  - state `ENTRY`; all outputs 0 (`bcd`, `ndig`, `value`, `start`, `locked`).
  - debounced levels set to released (1); debounce counters 0; synchronizers 1.
- Key latency: physical press → event pulse = 2 (sync) + `DEB_CNT` + 1 cycles.
- Register update: in the cycle after the event pulse.
- `start`: a registered output, high in the cycle after the go event. `locked` rises in the same cycle as `start`.
- `locked` falls in the cycle after `busy` is sampled 0 in `WAIT_DONE`.
- An event pulse coinciding with a state exit from `WAIT_DONE` is discarded.
- Reset asserted in any state returns to the reset values on the next edge. An in-flight `start` is not re-issued.
- `dec` is sampled only in the event cycle; it has no stability requirement otherwise.

## Structure
- `digit_entry_pkg` holds:
  - the state enum (`ENTRY`, `LAUNCH`, `WAIT_BUSY`, `WAIT_DONE`);
  - the digit limit constant `DEC_MAX` = 9;
  - the nibble width constant = 4.
- Sub-module `key_debounce` contains the synchronizer, the counter (parameter `DEB_CNT`), the debounced level and the press pulse. It is instantiated three times.
- The top level contains the FSM, the shift/accumulate datapath and the output registers.

## Test plan
All scenarios use `DEB_CNT` = 4.
- Reset: hold `reset` for 2 cycles → all outputs 0, state `ENTRY`; no event pulses even though keys read as released.
- Basic entry: press enter with `dec` = 1, then 2, then 3 → `bcd` = 0x0123, `value` = 123, `ndig` = 3, `start` never asserted.
- Saturation and guard:
  - enter 9, 9, 9, 9, then 7 → `bcd` = 0x9999, `value` = 9999, `ndig` = 4; the fifth press changes nothing.
  - separately, enter with `dec` = 12 → ignored.
- Debounce: a 3-cycle low glitch on `key_enter_n`, and bounce patterns shorter than `DEB_CNT` → no event. A clean press produces exactly one event, latency 7 cycles.
- Launch handshake:
  - go with `ndig` = 0 → no `start`.
  - after entering 4, 9: go → `start` high for exactly 1 cycle with `value` = 49, `locked` = 1.
  - enter and clear presses while `busy` = 1 → ignored.
  - `busy` falls → `locked` = 0 the next cycle, `bcd` still 0x0049.
- Simultaneous events and reset mid-operation:
  - clear and enter pulses in the same cycle → cleared, `ndig` = 0.
  - go and enter in the same cycle → launch with the old value.
  - reset asserted in `WAIT_DONE` → `ENTRY`, `locked` = 0, all outputs 0.

Source files
------------

// File: rtl/digit_entry_pkg.sv
// Shared types and constants for the keypad digit-entry stage.
package digit_entry_pkg;
  typedef enum logic [1:0] {ENTRY, LAUNCH, WAIT_BUSY, WAIT_DONE} state_e;
  localparam int         NIB_W   = 4;
  localparam logic [3:0] DEC_MAX = 4'd9;
endpackage

// File: rtl/digit_entry_key_debounce.sv
// Two-flop synchronizer, stable-sample debounce counter and press pulse for one active-low key.
module key_debounce #(
  parameter int DEB_CNT = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEB_CNT + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          last_q;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Level flips on the DEB_CNT-th consecutive disagreeing sample; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CNT - 1)) level_d = sync2_q;
      else                           cnt_d   = cnt_q + 1'b1;
    end
    press_d = last_q & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      last_q  <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      last_q  <= level_q;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;
endmodule

// File: rtl/digit_entry.sv
// Decimal keypad entry: BCD/binary accumulation, launch of the square-root core, lock while it runs.
module digit_entry
  import digit_entry_pkg::*;
#(
  parameter int NDIG    = 4,
  parameter int VW      = 14,
  parameter int DEB_CNT = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            dec,
  input  logic                  key_enter_n,
  input  logic                  key_go_n,
  input  logic                  key_clr_n,
  input  logic                  busy,
  output logic [NIB_W*NDIG-1:0] bcd,
  output logic [2:0]            ndig,
  output logic [VW-1:0]         value,
  output logic                  start,
  output logic                  locked
);
  logic enter_ev, go_ev, clr_ev;

  key_debounce #(.DEB_CNT(DEB_CNT)) u_enter (.clk(clk), .reset(reset), .key_n(key_enter_n), .press(enter_ev));
  key_debounce #(.DEB_CNT(DEB_CNT)) u_go    (.clk(clk), .reset(reset), .key_n(key_go_n),    .press(go_ev));
  key_debounce #(.DEB_CNT(DEB_CNT)) u_clr   (.clk(clk), .reset(reset), .key_n(key_clr_n),   .press(clr_ev));

  state_e                state_q, state_d;
  logic [NIB_W*NDIG-1:0] bcd_q, bcd_d;
  logic [VW-1:0]         value_q, value_d;
  logic [2:0]            ndig_q, ndig_d;
  logic                  start_q, start_d;
  logic                  locked_q, locked_d;

  // Key events are only honoured in ENTRY; everywhere else the operand is frozen for the core.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    value_d = value_q;
    ndig_d  = ndig_q;
    unique case (state_q)
      ENTRY: begin
        if (clr_ev) begin
          bcd_d   = '0;
          value_d = '0;
          ndig_d  = '0;
        end else if (go_ev) begin
          if (ndig_q != 3'd0) state_d = LAUNCH;
        end else if (enter_ev && ndig_q < 3'(NDIG) && dec <= DEC_MAX) begin
          bcd_d   = {bcd_q[NIB_W*NDIG-NIB_W-1:0], dec};
          value_d = (value_q << 3) + (value_q << 1) + VW'(dec);
          ndig_d  = ndig_q + 3'd1;
        end
      end
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: if (busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!busy) state_d = ENTRY;
      default:   state_d = ENTRY;
    endcase
    start_d  = (state_d == LAUNCH);
    locked_d = (state_d != ENTRY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ENTRY;
      bcd_q    <= '0;
      value_q  <= '0;
      ndig_q   <= '0;
      start_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      value_q  <= value_d;
      ndig_q   <= ndig_d;
      start_q  <= start_d;
      locked_q <= locked_d;
    end
  end

  assign bcd    = bcd_q;
  assign ndig   = ndig_q;
  assign value  = value_q;
  assign start  = start_q;
  assign locked = locked_q;
endmodule

// File: tb/tb_digit_entry.sv
// Scoreboard bench for digit_entry: each expected output change is queued, a monitor checks every change.
module tb_digit_entry;
  typedef struct packed {
    logic [15:0] bcd;
    logic [2:0]  ndig;
    logic [13:0] value;
    logic        start;
    logic        locked;
  } snap_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  dec = 4'd0;
  logic        key_enter_n = 1'b1, key_go_n = 1'b1, key_clr_n = 1'b1;
  logic        busy = 1'b0;
  logic [15:0] bcd;
  logic [2:0]  ndig;
  logic [13:0] value;
  logic        start, locked;

  digit_entry #(.NDIG(4), .VW(14), .DEB_CNT(4)) dut (
    .clk(clk), .reset(reset), .dec(dec),
    .key_enter_n(key_enter_n), .key_go_n(key_go_n), .key_clr_n(key_clr_n),
    .busy(busy), .bcd(bcd), .ndig(ndig), .value(value),
    .start(start), .locked(locked)
  );

  always #5 clk = ~clk;

  snap_t exp_q[$];
  int    total = 0, bad = 0;
  bit    mon_en = 1'b0;
  snap_t cur;
  assign cur = {bcd, ndig, value, start, locked};

  // Monitor: every change of the output bundle must match the next queued expectation.
  initial begin
    snap_t prev, e;
    forever begin
      @(negedge clk);
      if (!mon_en) prev = cur;
      else if (cur !== prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change got=%h", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            bad++;
            $display("FAIL output_change got=%h want=%h", cur, e);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] b, input logic [2:0] n, input logic [13:0] v,
                      input logic s, input logic l);
    exp_q.push_back({b, n, v, s, l});
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic press(input bit e, input bit g, input bit c, input logic [3:0] d);
    @(negedge clk);
    dec = d;
    if (e) key_enter_n = 1'b0;
    if (g) key_go_n    = 1'b0;
    if (c) key_clr_n   = 1'b0;
    cyc(12);
    key_enter_n = 1'b1;
    key_go_n    = 1'b1;
    key_clr_n   = 1'b1;
    cyc(10);
  endtask

  initial begin
    int          n;
    logic [15:0] pat;

    // reset
    cyc(2);
    reset = 1'b0;
    cyc(3);
    chk("rst_bcd", 32'(bcd), 0);
    chk("rst_ndig", 32'(ndig), 0);
    chk("rst_value", 32'(value), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_locked", 32'(locked), 0);
    mon_en = 1'b1;

    // go with nothing entered
    press(0, 1, 0, 4'd0);

    // first digit, with latency measurement: 7 to event + 1 to register
    push(16'h0001, 3'd1, 14'd1, 0, 0);
    @(negedge clk);
    dec = 4'd1;
    key_enter_n = 1'b0;
    n = 0;
    while (ndig == 3'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("enter_latency", 32'(n), 8);
    cyc(4);
    key_enter_n = 1'b1;
    cyc(10);

    push(16'h0012, 3'd2, 14'd12, 0, 0);  press(1, 0, 0, 4'd2);
    push(16'h0123, 3'd3, 14'd123, 0, 0); press(1, 0, 0, 4'd3);

    // saturation
    push(16'h0000, 3'd0, 14'd0, 0, 0);    press(0, 0, 1, 4'd0);
    push(16'h0009, 3'd1, 14'd9, 0, 0);    press(1, 0, 0, 4'd9);
    push(16'h0099, 3'd2, 14'd99, 0, 0);   press(1, 0, 0, 4'd9);
    push(16'h0999, 3'd3, 14'd999, 0, 0);  press(1, 0, 0, 4'd9);
    push(16'h9999, 3'd4, 14'd9999, 0, 0); press(1, 0, 0, 4'd9);
    press(1, 0, 0, 4'd7);

    // invalid digit
    push(16'h0000, 3'd0, 14'd0, 0, 0);    press(0, 0, 1, 4'd0);
    press(1, 0, 0, 4'd12);

    // glitch and bounce, no low run reaches 4 samples
    @(negedge clk);
    key_enter_n = 1'b0;
    cyc(3);
    key_enter_n = 1'b1;
    cyc(8);
    pat = 16'b1111_0001_0100_0100;
    for (int i = 0; i < 16; i++) begin
      key_enter_n = pat[i];
      @(negedge clk);
    end
    cyc(10);

    // launch handshake
    push(16'h0004, 3'd1, 14'd4, 0, 0);   press(1, 0, 0, 4'd4);
    push(16'h0049, 3'd2, 14'd49, 0, 0);  press(1, 0, 0, 4'd9);
    push(16'h0049, 3'd2, 14'd49, 1, 1);
    push(16'h0049, 3'd2, 14'd49, 0, 1);
    press(0, 1, 0, 4'd0);
    busy = 1'b1;
    cyc(3);
    press(1, 0, 0, 4'd5);
    press(0, 0, 1, 4'd0);
    push(16'h0049, 3'd2, 14'd49, 0, 0);
    busy = 1'b0;
    cyc(4);
    chk("post_busy_bcd", 32'(bcd), 32'h0049);

    // clear and enter together
    push(16'h0000, 3'd0, 14'd0, 0, 0);   press(1, 0, 1, 4'd7);

    // go and enter together launches the old operand
    push(16'h0005, 3'd1, 14'd5, 0, 0);   press(1, 0, 0, 4'd5);
    push(16'h0005, 3'd1, 14'd5, 1, 1);
    push(16'h0005, 3'd1, 14'd5, 0, 1);
    press(1, 1, 0, 4'd6);
    busy = 1'b1;
    cyc(3);

    // reset in WAIT_DONE
    push(16'h0000, 3'd0, 14'd0, 0, 0);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    busy = 1'b0;
    cyc(5);
    chk("mid_rst_locked", 32'(locked), 0);
    chk("mid_rst_start", 32'(start), 0);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
